// File: rtl/prog_clk_divider.sv
// Programmable divide-by-N stage with a one-cycle period-start tick.
// Ratio changes and stop requests are only accepted at period boundaries.
module prog_clk_divider #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] ratio,
  output logic             div_out,
  output logic             tick,
  output logic [WIDTH-1:0] cur_ratio
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [WIDTH-1:0] ONE   = WIDTH'(1);
  localparam logic [WIDTH:0]   ONE_W = (WIDTH + 1)'(1);

  state_t           state;
  logic [WIDTH-1:0] cnt;
  logic             start;
  logic             boundary;
  logic [WIDTH:0]   half;
  logic [WIDTH:0]   cnt_inc;

  assign start    = en && (ratio != '0);
  assign boundary = (cnt == (cur_ratio - ONE));
  // One extra bit so that N = 2**WIDTH-1 rounds up without wrapping.
  assign half     = ({1'b0, cur_ratio} + ONE_W) >> 1;
  assign cnt_inc  = {1'b0, cnt} + ONE_W;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= '0;
      cur_ratio <= '0;
      div_out   <= 1'b0;
      tick      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          cnt <= '0;
          if (start) begin
            state     <= RUN;
            cur_ratio <= ratio;
            tick      <= 1'b1;
            div_out   <= 1'b1;
          end else begin
            cur_ratio <= '0;
            tick      <= 1'b0;
            div_out   <= 1'b0;
          end
        end
        RUN: begin
          if (boundary) begin
            cnt <= '0;
            if (start) begin
              cur_ratio <= ratio;
              tick      <= 1'b1;
              div_out   <= 1'b1;
            end else begin
              state     <= IDLE;
              cur_ratio <= '0;
              tick      <= 1'b0;
              div_out   <= 1'b0;
            end
          end else begin
            // cnt stays below cur_ratio-1 here, so the truncation cannot wrap.
            cnt     <= cnt_inc[WIDTH-1:0];
            tick    <= 1'b0;
            div_out <= (cnt_inc < half);
          end
        end
        default: begin
          state     <= IDLE;
          cnt       <= '0;
          cur_ratio <= '0;
          tick      <= 1'b0;
          div_out   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_prog_clk_divider.sv
// Randomised scoreboard bench for prog_clk_divider: a period-level reference
// model queues expected outputs per clock, a monitor pops and compares them.
module tb_prog_clk_divider;

  localparam int WIDTH = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             en = 1'b0;
  logic [WIDTH-1:0] ratio = '0;
  logic             div_out;
  logic             tick;
  logic [WIDTH-1:0] cur_ratio;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic             d;
    logic             t;
    logic [WIDTH-1:0] c;
  } exp_t;

  exp_t period_q[$];
  exp_t exp_q[$];

  always #5 clk = ~clk;

  prog_clk_divider #(.WIDTH(WIDTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .ratio    (ratio),
    .div_out  (div_out),
    .tick     (tick),
    .cur_ratio(cur_ratio)
  );

  // A whole period of N cycles: high for the first ceil(N/2) cycles, tick on the first.
  function automatic void load_period(int n);
    for (int i = 0; i < n; i++) begin
      exp_t e;
      e.d = (2 * i < n);
      e.t = (i == 0);
      e.c = WIDTH'(n);
      period_q.push_back(e);
    end
  endfunction

  // Reference model: a new period (or idle) is decided only when the previous one is used up.
  always @(negedge rst) period_q.delete();

  always @(posedge clk) begin
    exp_t e;
    e = '0;
    if (!rst) begin
      period_q.delete();
    end else begin
      if (period_q.size() == 0 && en && ratio != '0)
        load_period(int'(ratio));
      if (period_q.size() != 0)
        e = period_q.pop_front();
    end
    exp_q.push_back(e);
  end

  // Monitor: outputs are presented every cycle; compare away from the rising edge.
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      total++;
      if (div_out !== e.d || tick !== e.t || cur_ratio !== e.c) begin
        bad++;
        $display("FAIL cycle_check t=%0t: got div_out=%0b tick=%0b cur_ratio=%0d, want div_out=%0b tick=%0b cur_ratio=%0d",
                 $time, div_out, tick, cur_ratio, e.d, e.t, e.c);
      end
    end
  end

  task automatic wait_tick(string tag);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (tick !== 1'b1 && n < 40);
    if (tick !== 1'b1) begin
      total++;
      bad++;
      $display("FAIL %s_timeout: got no tick in 40 cycles, want a tick", tag);
    end
  endtask

  // Assert reset between clock edges and check the outputs clear without waiting for a clock.
  task automatic async_reset_pulse(int hold);
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    total++;
    if (div_out !== 1'b0 || tick !== 1'b0 || cur_ratio !== '0) begin
      bad++;
      $display("FAIL async_reset: got div_out=%0b tick=%0b cur_ratio=%0d, want all 0",
               div_out, tick, cur_ratio);
    end
    repeat (hold) @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    // Reset held with en low, then idle.
    $display("scenario reset_idle");
    repeat (5) @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);

    $display("scenario ratio_4");
    en = 1'b1;
    ratio = 4'd4;
    repeat (12) @(negedge clk);

    $display("scenario ratio_3_1_15");
    ratio = 4'd3;
    repeat (9) @(negedge clk);
    ratio = 4'd1;
    repeat (5) @(negedge clk);
    ratio = 4'd15;
    repeat (32) @(negedge clk);

    // Ratio change mid-period at cnt=1.
    $display("scenario change_4_to_6");
    ratio = 4'd4;
    repeat (20) @(negedge clk);
    wait_tick("chg");
    @(negedge clk);
    ratio = 4'd6;
    repeat (16) @(negedge clk);

    // en dropped at cnt=1, then ratio=0 start attempt.
    $display("scenario stop_mid_period");
    ratio = 4'd4;
    repeat (10) @(negedge clk);
    wait_tick("stop");
    @(negedge clk);
    en = 1'b0;
    repeat (8) @(negedge clk);
    ratio = 4'd0;
    en = 1'b1;
    repeat (5) @(negedge clk);

    // Async reset at cnt=2 of an N=6 period, then restart.
    $display("scenario reset_mid_period");
    ratio = 4'd6;
    wait_tick("rst");
    @(negedge clk);
    async_reset_pulse(2);
    repeat (10) @(negedge clk);

    $display("scenario random");
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 3) == 0) ratio = WIDTH'($urandom_range(0, 15));
      if ($urandom_range(0, 7) == 0) en = ~en;
      if ($urandom_range(0, 199) == 0) async_reset_pulse(int'($urandom_range(0, 3)));
    end
    repeat (3) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
